// File: rtl/wallace_pkg.sv
// Shared widths and row type for the pipelined Wallace-tree multiplier.
package wallace_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 2 * OP_W;

  typedef logic [PROD_W-1:0] csa_row_t;

endpackage : wallace_pkg

// File: rtl/wallace_multiplier_if.sv
// Operand/product bundle for the multiplier; no handshake, every cycle is a transfer.
interface wallace_multiplier_if
  import wallace_pkg::*;
#(
  parameter int WIDTH = OP_W
);

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] p;

  modport master (output a, output b, input p);
  modport slave  (input a, input b, output p);

endinterface : wallace_multiplier_if

// File: rtl/wallace_multiplier_csa_3to2.sv
// Bit-vector 3:2 compressor over N independent row groups; a half adder is z = 0.
module csa_3to2
  import wallace_pkg::*;
#(
  parameter int N = 1
) (
  input  csa_row_t [N-1:0] x,
  input  csa_row_t [N-1:0] y,
  input  csa_row_t [N-1:0] z,
  output csa_row_t [N-1:0] sum,
  output csa_row_t [N-1:0] carry
);

  for (genvar g = 0; g < N; g++) begin : g_grp
    assign sum[g]   = x[g] ^ y[g] ^ z[g];
    // Carry out of the top bit is dropped; rows are summed modulo 2^PROD_W.
    assign carry[g] = ((x[g] & y[g]) | (x[g] & z[g]) | (y[g] & z[g])) << 1;
  end

endmodule : csa_3to2

// File: rtl/wallace_multiplier.sv
// Four-rank pipelined unsigned multiplier: operand regs, CSA levels 1-3, levels 4-6, final add.
module wallace_multiplier
  import wallace_pkg::*;
#(
  parameter int WIDTH = OP_W
) (
  input logic clk,
  input logic rst,
  wallace_multiplier_if.slave bus
);

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  csa_row_t [5:0]    st2_q;
  csa_row_t [1:0]    st3_q;
  logic [PROD_W-1:0] p_q;

  csa_row_t [15:0] pp;

  for (genvar j = 0; j < 16; j++) begin : g_pp
    assign pp[j] = b_q[j] ? (csa_row_t'(a_q) << j) : '0;
  end

  // Level 1: 16 -> 11
  csa_row_t [4:0]  l1_x, l1_y, l1_z, l1_s, l1_c;
  csa_row_t [10:0] rows1;

  for (genvar g = 0; g < 5; g++) begin : g_l1
    assign l1_x[g] = pp[3*g];
    assign l1_y[g] = pp[3*g+1];
    assign l1_z[g] = pp[3*g+2];
  end

  csa_3to2 #(.N(5)) u_lvl1 (
    .x(l1_x), .y(l1_y), .z(l1_z), .sum(l1_s), .carry(l1_c)
  );

  assign rows1 = {pp[15], l1_c, l1_s};

  // Level 2: 11 -> 8
  csa_row_t [2:0] l2_x, l2_y, l2_z, l2_s, l2_c;
  csa_row_t [7:0] rows2;

  for (genvar g = 0; g < 3; g++) begin : g_l2
    assign l2_x[g] = rows1[3*g];
    assign l2_y[g] = rows1[3*g+1];
    assign l2_z[g] = rows1[3*g+2];
  end

  csa_3to2 #(.N(3)) u_lvl2 (
    .x(l2_x), .y(l2_y), .z(l2_z), .sum(l2_s), .carry(l2_c)
  );

  assign rows2 = {rows1[10], rows1[9], l2_c, l2_s};

  // Level 3: 8 -> 6
  csa_row_t [1:0] l3_x, l3_y, l3_z, l3_s, l3_c;
  csa_row_t [5:0] rows3;

  for (genvar g = 0; g < 2; g++) begin : g_l3
    assign l3_x[g] = rows2[3*g];
    assign l3_y[g] = rows2[3*g+1];
    assign l3_z[g] = rows2[3*g+2];
  end

  csa_3to2 #(.N(2)) u_lvl3 (
    .x(l3_x), .y(l3_y), .z(l3_z), .sum(l3_s), .carry(l3_c)
  );

  assign rows3 = {rows2[7], rows2[6], l3_c, l3_s};

  // Level 4: 6 -> 4, fed from rank R2
  csa_row_t [1:0] l4_x, l4_y, l4_z, l4_s, l4_c;
  csa_row_t [3:0] rows4;

  for (genvar g = 0; g < 2; g++) begin : g_l4
    assign l4_x[g] = st2_q[3*g];
    assign l4_y[g] = st2_q[3*g+1];
    assign l4_z[g] = st2_q[3*g+2];
  end

  csa_3to2 #(.N(2)) u_lvl4 (
    .x(l4_x), .y(l4_y), .z(l4_z), .sum(l4_s), .carry(l4_c)
  );

  assign rows4 = {l4_c, l4_s};

  // Level 5: 4 -> 3
  csa_row_t [0:0] l5_x, l5_y, l5_z, l5_s, l5_c;
  csa_row_t [2:0] rows5;

  assign l5_x[0] = rows4[0];
  assign l5_y[0] = rows4[1];
  assign l5_z[0] = rows4[2];

  csa_3to2 #(.N(1)) u_lvl5 (
    .x(l5_x), .y(l5_y), .z(l5_z), .sum(l5_s), .carry(l5_c)
  );

  assign rows5 = {rows4[3], l5_c, l5_s};

  // Level 6: 3 -> 2
  csa_row_t [0:0] l6_x, l6_y, l6_z, l6_s, l6_c;
  csa_row_t [1:0] rows6;

  assign l6_x[0] = rows5[0];
  assign l6_y[0] = rows5[1];
  assign l6_z[0] = rows5[2];

  csa_3to2 #(.N(1)) u_lvl6 (
    .x(l6_x), .y(l6_y), .z(l6_z), .sum(l6_s), .carry(l6_c)
  );

  assign rows6 = {l6_c, l6_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      st2_q <= '0;
      st3_q <= '0;
      p_q   <= '0;
    end else begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      st2_q <= rows3;
      st3_q <= rows6;
      p_q   <= st3_q[0] + st3_q[1];
    end
  end

  assign bus.p = p_q;

endmodule : wallace_multiplier

// File: tb/tb_wallace_multiplier.sv
// Scoreboard bench: driver queues expected products, monitor checks p three edges later.
module tb_wallace_multiplier;
  import wallace_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wallace_multiplier_if #(.WIDTH(16)) bus ();

  wallace_multiplier #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic r,
                       input logic [31:0] exp_p, input string tag);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    rst   = r;
    if (!r) begin
      exp_q.push_back(exp_p);
      tag_q.push_back(tag);
    end
  endtask

  task automatic drive_rand(input string tag);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'($urandom());
    b = 16'($urandom());
    case ($urandom_range(7, 0))
      0: a = 16'hFFFF;
      1: b = 16'hFFFF;
      2: a = 16'h0000;
      default: ;
    endcase
    drive(a, b, 1'b0, 32'(a) * 32'(b), tag);
  endtask

  // A reset edge empties the pipe: p is 0 now and for the next three edges.
  always @(posedge clk) begin
    logic [31:0] exp_p;
    logic [31:0] p_hold;
    string       tag;
    #1;
    if (rst) begin
      checks++;
      if (bus.p !== 32'h0) begin
        failures++;
        $display("FAIL reset_zero: p=%h expected=%h", bus.p, 32'h0);
      end
      exp_q.delete();
      tag_q.delete();
      repeat (3) begin
        exp_q.push_back(32'h0);
        tag_q.push_back("post_reset_zero");
      end
    end else if (exp_q.size() >= 4) begin
      exp_p = exp_q.pop_front();
      tag   = tag_q.pop_front();
      checks++;
      if (bus.p !== exp_p) begin
        failures++;
        $display("FAIL %s: p=%h expected=%h", tag, bus.p, exp_p);
      end
    end
    p_hold = bus.p;
    #7;
    checks++;
    if (bus.p !== p_hold) begin
      failures++;
      $display("FAIL p_stable: p=%h expected=%h", bus.p, p_hold);
    end
  end

  initial begin
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    rst   = 1'b1;
    drive(16'hFFFF, 16'hFFFF, 1'b1, 32'h0, "rst_hold");

    drive(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "max_max");
    drive(16'h0000, 16'h1234, 1'b0, 32'h00000000, "zero_a");
    drive(16'h0001, 16'hABCD, 1'b0, 32'h0000ABCD, "one_a");
    drive(16'h8000, 16'h8000, 1'b0, 32'h40000000, "pow2_top");
    drive(16'h8000, 16'h0002, 1'b0, 32'h00010000, "pow2_shift");
    drive(16'h0003, 16'h0005, 1'b0, 32'h0000000F, "stream_0");
    drive(16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, "stream_1");
    drive(16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF, "stream_2");

    for (int i = 0; i < 40; i++) drive_rand("rand_pre");

    for (int i = 0; i < 3; i++) drive_rand("inflight");
    drive(16'hFFFF, 16'hFFFF, 1'b1, 32'h0, "mid_reset");
    drive(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "after_reset");

    for (int i = 0; i < 10000; i++) drive_rand("rand_soak");

    for (int i = 0; i < 4; i++) drive(16'h0, 16'h0, 1'b0, 32'h0, "flush");
    repeat (2) @(posedge clk);
    #9;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wallace_multiplier
